onchip_mem_arbiter: RTL
=======================

Name: onchip_mem_arbiter

Overview:
- Two-master arbiter sharing the single-port 8000 x 32-bit on-chip RAM (13-bit word address, 4-bit byteenable).
- The RAM registers its address and has an unregistered output, so read data is valid on the cycle after issue.
- Sits between two Avalon-MM masters (CPU data master, DMA) and the RAM slave port.
- Handles per-cycle grant, waitrequest generation, read-data return routing, out-of-range protection and contention statistics.

Parameters:
- DEPTH, 8000, number of valid RAM words; addresses >= DEPTH are out-of-range.
- AW, 13, word address width.
- DW, 32, data width; byteenable width is DW/8.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (m0 always wins).
- CNT_W, 16, contention counter width.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- m0_address / m1_address  in  AW  word address.
- m0_byteenable / m1_byteenable  in  DW/8  byte lanes.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  DW  write data.
- m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle.
- m0_readdata / m1_readdata  out  DW  returned read data.
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid strobe.
- mem_address  out  AW  to RAM.
- mem_byteenable  out  DW/8  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  DW  to RAM.
- mem_clken  out  1  to RAM; tied to 1.
- mem_readdata  in  DW  from RAM.
- err_clear  in  1  synchronous clear of the error flags.
- err_oob  out  1  sticky: an out-of-range access occurred.
- err_proto  out  1  sticky: read and write asserted together.
- contention_cnt  out  CNT_W  saturating count of cycles in which both masters requested.

Behaviour:
- Request: req_i = mi_read | mi_write.
- Grant is combinational from req0, req1 and the registered last_grant.
  - PRIO_MODE=0: when both request, grant the master that is not last_grant.
  - PRIO_MODE=1: m0 wins whenever it requests.
  - With one requester, that master is granted.
- Waitrequest:
  - Granted master: waitrequest = 0.
  - Any other requesting master: waitrequest = 1.
  - Idle master: waitrequest = 0.
  - While reset_n is low, both waitrequests are forced to 1.
- Issue, same cycle as grant:
  - mem_address, mem_byteenable and mem_writedata are muxed from the winner.
  - mem_chipselect = granted & in-range.
  - mem_write = chipselect & winner write.
- last_grant updates on every granted cycle. Reset value selects m1, so m0 wins the first tie.
- Read return:
  - A registered pending flag, owner tag and oob flag are captured on an accepted read.
  - Next cycle: owner's readdatavalid = 1; readdata = mem_readdata, or 0 if oob.
  - Latency is exactly 1 cycle. Back-to-back reads are fully pipelined (throughput 1 per cycle), including alternating owners.
  - The non-owner's readdatavalid = 0 and its readdata holds its last value.
- Out-of-range (address >= DEPTH):
  - The request is accepted (waitrequest 0) but not driven to the RAM.
  - Writes are dropped; reads return 0 with a valid strobe.
  - err_oob is set.
- read & write asserted together: treated as a write, err_proto set.
- Error flags: err_clear clears them; a new error event in the same cycle as err_clear wins (flag stays set).
- contention_cnt: increments when req0 & req1; saturates at all-ones.
- Reset values: readdatavalid 0, readdata 0, err flags 0, contention_cnt 0, pending 0.
- Reset mid-read: the pending read is discarded; no readdatavalid is produced after reset release.

Decomposition:
- Shared package: master-index constants (M0 = 0, M1 = 1), PRIO_MODE encodings, DEPTH default.
- One natural sub-module: rr_arbiter2, the 2-way grant logic with the last_grant register.
- Datapath mux, return pipeline and error/stat logic stay in the top module.

Test Plan:
- m0 writes 0xDEADBEEF to addr 5 with byteenable 0xF; next cycle m0 reads addr 5 -> m0_readdatavalid one cycle after issue, readdata 0xDEADBEEF; m1 sees no strobe.
- Both masters read every cycle for 4 cycles, PRIO_MODE=0 -> grants m0,m1,m0,m1; each waitrequest alternates; contention_cnt = 4.
- Same stimulus with PRIO_MODE=1 -> m0 is granted all 4 cycles; m1_waitrequest stays 1 throughout.
- m1 writes addr 8000 -> mem_chipselect stays 0 and err_oob = 1; m1 reads addr 8191 -> readdata 0 with valid; err_clear pulse -> err_oob = 0.
- Byte write with byteenable 0x2, data 0x0000AB00, over 0x11223344 -> readback 0x1122AB44.
- Assert reset_n low in the cycle after a read is issued -> no readdatavalid, both waitrequests 1 during reset, counters and flags 0 after release.

Source files
------------

// File: rtl/onchip_mem_arbiter_pkg.sv
// rtl/onchip_mem_arbiter_pkg.sv - shared constants for the on-chip RAM arbiter
package onchip_mem_arbiter_pkg;

    // Master indices used for grant, last_grant and read-return ownership
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Arbitration policy encodings
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // Number of implemented RAM words
    localparam int DEPTH_DEFAULT = 8000;

endpackage

// File: rtl/onchip_mem_arbiter_rr_arbiter2.sv
// rtl/onchip_mem_arbiter_rr_arbiter2.sv - two-way grant logic with last_grant history
module onchip_mem_arbiter_rr_arbiter2
    import onchip_mem_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last_grant;

    // Combinational grant: on a tie, fixed mode favours m0, round-robin favours the master not served last
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = M0;
        if (req[0] && req[1]) begin
            if (PRIO_MODE == PRIO_FIXED) begin
                gnt_idx = M0;
            end else begin
                gnt_idx = ~last_grant;
            end
        end else if (req[1]) begin
            gnt_idx = M1;
        end
    end

    // Remember the winner of every granted cycle; reset to m1 so m0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= M1;
        end else if (gnt_valid) begin
            last_grant <= gnt_idx;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - two-master arbiter in front of the single-port on-chip RAM
module onchip_mem_arbiter
    import onchip_mem_arbiter_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int AW        = 13,
    parameter int DW        = 32,
    parameter int PRIO_MODE = PRIO_RR,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     m0_address,
    input  logic [DW/8-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DW-1:0]     m0_writedata,
    output logic              m0_waitrequest,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [AW-1:0]     m1_address,
    input  logic [DW/8-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DW-1:0]     m1_writedata,
    output logic              m1_waitrequest,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_readdatavalid,
    output logic [AW-1:0]     mem_address,
    output logic [DW/8-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DW-1:0]     mem_writedata,
    output logic              mem_clken,
    input  logic [DW-1:0]     mem_readdata,
    input  logic              err_clear,
    output logic              err_oob,
    output logic              err_proto,
    output logic [CNT_W-1:0]  contention_cnt
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [1:0]      req;
    logic            gnt_valid;
    logic            gnt_idx;
    logic [AW-1:0]   sel_addr;
    logic [DW/8-1:0] sel_be;
    logic [DW-1:0]   sel_wdata;
    logic            sel_read;
    logic            sel_write;
    logic            sel_oob;
    logic            accept_read;

    logic            rd_pending;
    logic            rd_owner;
    logic            rd_oob;
    logic [DW-1:0]   ret_data;
    logic [DW-1:0]   rd_hold0;
    logic [DW-1:0]   rd_hold1;

    // Requests are ignored while in reset so nothing is granted or counted
    assign req = {m1_read | m1_write, m0_read | m0_write} & {2{reset_n}};

    onchip_mem_arbiter_rr_arbiter2 #(
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk       (clk),
        .rst_n     (reset_n),
        .req       (req),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Select the winning master's command fields
    always_comb begin
        sel_addr  = m0_address;
        sel_be    = m0_byteenable;
        sel_wdata = m0_writedata;
        sel_read  = m0_read;
        sel_write = m0_write;
        if (gnt_idx == M1) begin
            sel_addr  = m1_address;
            sel_be    = m1_byteenable;
            sel_wdata = m1_writedata;
            sel_read  = m1_read;
            sel_write = m1_write;
        end
    end

    assign sel_oob     = {1'b0, sel_addr} >= DEPTH_W;
    // read+write together is a write, so only a pure read produces a return
    assign accept_read = gnt_valid & sel_read & ~sel_write;

    assign mem_address    = sel_addr;
    assign mem_byteenable = sel_be;
    assign mem_writedata  = sel_wdata;
    assign mem_chipselect = gnt_valid & ~sel_oob;
    assign mem_write      = mem_chipselect & sel_write;
    assign mem_clken      = 1'b1;

    // A requester that lost arbitration stalls; in reset both masters are held off
    assign m0_waitrequest = ~reset_n | (req[0] & ~(gnt_valid & (gnt_idx == M0)));
    assign m1_waitrequest = ~reset_n | (req[1] & ~(gnt_valid & (gnt_idx == M1)));

    // Out-of-range reads never touched the RAM, so they return zero
    assign ret_data         = rd_oob ? '0 : mem_readdata;
    assign m0_readdatavalid = rd_pending & (rd_owner == M0);
    assign m1_readdatavalid = rd_pending & (rd_owner == M1);
    assign m0_readdata      = m0_readdatavalid ? ret_data : rd_hold0;
    assign m1_readdata      = m1_readdatavalid ? ret_data : rd_hold1;

    // One-deep return tag: RAM data appears the cycle after issue, so one entry sustains full throughput
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending <= 1'b0;
            rd_owner   <= M0;
            rd_oob     <= 1'b0;
        end else begin
            rd_pending <= accept_read;
            rd_owner   <= gnt_idx;
            rd_oob     <= sel_oob;
        end
    end

    // Keep each master's last returned word visible between strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_hold0 <= '0;
            rd_hold1 <= '0;
        end else begin
            if (m0_readdatavalid) begin
                rd_hold0 <= ret_data;
            end
            if (m1_readdatavalid) begin
                rd_hold1 <= ret_data;
            end
        end
    end

    // Sticky error flags; a fresh event beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_oob   <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            if (gnt_valid && sel_oob) begin
                err_oob <= 1'b1;
            end else if (err_clear) begin
                err_oob <= 1'b0;
            end
            if (gnt_valid && sel_read && sel_write) begin
                err_proto <= 1'b1;
            end else if (err_clear) begin
                err_proto <= 1'b0;
            end
        end
    end

    // Saturating count of cycles with both masters requesting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            contention_cnt <= '0;
        end else if ((&req) && (contention_cnt != {CNT_W{1'b1}})) begin
            contention_cnt <= contention_cnt + 1'b1;
        end
    end

endmodule
